sfx_scheduler: RTL and testbench



---
 rtl/sfx_pkg.sv | 22 ++
 rtl/sfx_prio_enc.sv | 22 ++
 rtl/sfx_scheduler.sv | 152 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect scheduler.
package sfx_pkg;

    // START is folded into the IDLE->WAIT_ACK transition, so the start cycle already reads WAIT_ACK.
    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        PLAYING,
        STOP_WAIT,
        GAP
    } sfx_state_t;

    localparam int SFX_PASS = 0;
    localparam int SFX_FAIL = 1;
    localparam int SFX_HIT  = 2;
    localparam int SFX_TICK = 3;

    localparam int unsigned DEFAULT_GAP_CYCLES  = 5_000_000;
    localparam int unsigned DEFAULT_ACK_TIMEOUT = 1_000;

endpackage

// File: rtl/sfx_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module sfx_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Arbitrates game-event sound effects onto the single melody player, with
// priority selection, preemption, mute, an inter-effect gap and an ack timeout.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int          NUM_SFX      = 4,
    parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES,
    parameter int unsigned ACK_TIMEOUT  = DEFAULT_ACK_TIMEOUT,
    parameter logic [NUM_SFX-1:0] PREEMPT_MASK = NUM_SFX'(1),
    localparam int         ID_W         = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SFX-1:0] sfx_req,
    input  logic               mute,
    input  logic               player_busy,
    output logic               player_start,
    output logic               player_stop,
    output logic [ID_W-1:0]    player_id,
    output logic [NUM_SFX-1:0] pending,
    output logic               active,
    output logic               ack_err
);

    sfx_state_t         state;
    logic [31:0]        cnt;

    logic [NUM_SFX-1:0] cand;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx;
    logic               pre_valid;
    logic [ID_W-1:0]    pre_idx;
    logic               preempt_hit;
    logic               start_now;
    logic [NUM_SFX-1:0] issue_bit;
    logic [NUM_SFX-1:0] pending_next;

    assign cand = pending | sfx_req;

    sfx_prio_enc #(.N(NUM_SFX), .IW(ID_W)) u_sel_enc (
        .req   (cand),
        .valid (sel_valid),
        .index (sel_idx)
    );

    sfx_prio_enc #(.N(NUM_SFX), .IW(ID_W)) u_pre_enc (
        .req   (cand & PREEMPT_MASK),
        .valid (pre_valid),
        .index (pre_idx)
    );

    assign preempt_hit = pre_valid && (pre_idx < player_id);

    // A start can launch from IDLE, the last gap cycle, or straight out of a preemption stop.
    always_comb begin
        start_now = 1'b0;
        if (sel_valid && !mute) begin
            case (state)
                IDLE:      start_now = 1'b1;
                GAP:       start_now = (cnt <= 32'd1);
                STOP_WAIT: start_now = !player_busy;
                default:   start_now = 1'b0;
            endcase
        end
    end

    // A request that is issued in the cycle it arrives is consumed; a fresh pulse
    // for an already-latched effect survives the issue and plays again later.
    always_comb begin
        issue_bit = start_now ? (NUM_SFX'(1) << sel_idx) : '0;
        if (mute) begin
            pending_next = '0;
        end else begin
            pending_next = (pending & ~issue_bit) | (sfx_req & ~(issue_bit & ~pending));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            player_start <= 1'b0;
            player_stop  <= 1'b0;
            player_id    <= '0;
            pending      <= '0;
            active       <= 1'b0;
            ack_err      <= 1'b0;
        end else begin
            player_start <= 1'b0;
            player_stop  <= 1'b0;
            ack_err      <= 1'b0;
            pending      <= pending_next;

            if (start_now) begin
                player_start <= 1'b1;
                player_id    <= sel_idx;
                state        <= WAIT_ACK;
                cnt          <= 32'(ACK_TIMEOUT);
                active       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        active <= 1'b0;
                    end
                    WAIT_ACK: begin
                        if (mute) begin
                            player_stop <= 1'b1;
                            state       <= STOP_WAIT;
                        end else if (player_busy) begin
                            state <= PLAYING;
                        end else if (cnt <= 32'd1) begin
                            ack_err <= 1'b1;
                            state   <= GAP;
                            cnt     <= 32'(GAP_CYCLES);
                            active  <= 1'b0;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    PLAYING: begin
                        if (mute || (player_busy && preempt_hit)) begin
                            player_stop <= 1'b1;
                            state       <= STOP_WAIT;
                        end else if (!player_busy) begin
                            state  <= GAP;
                            cnt    <= 32'(GAP_CYCLES);
                            active <= 1'b0;
                        end
                    end
                    STOP_WAIT: begin
                        if (!player_busy) begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (cnt <= 32'd1) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Randomised and scenario bench for sfx_scheduler against a deadline-based
// reference model and a simple melody-player model.
module tb_sfx_scheduler;

    localparam int N = 4;
    localparam int G = 4;
    localparam int A = 8;
    localparam logic [N-1:0] PMASK = 4'b0001;

    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_STOPW = 3;
    localparam int PH_GAP   = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] sfx_req;
    logic         mute;
    logic         player_busy;
    logic         player_start;
    logic         player_stop;
    logic [1:0]   player_id;
    logic [N-1:0] pending;
    logic         active;
    logic         ack_err;

    always #5 clk = ~clk;

    sfx_scheduler #(
        .NUM_SFX      (N),
        .GAP_CYCLES   (G),
        .ACK_TIMEOUT  (A),
        .PREEMPT_MASK (PMASK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sfx_req      (sfx_req),
        .mute         (mute),
        .player_busy  (player_busy),
        .player_start (player_start),
        .player_stop  (player_stop),
        .player_id    (player_id),
        .pending      (pending),
        .active       (active),
        .ack_err      (ack_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state: phase plus absolute-cycle deadlines
    int           ph;
    logic [N-1:0] m_pend;
    int           m_id;
    int           start_at;
    int           gap_last;
    logic         e_start, e_stop, e_err, e_active;

    // melody player model
    int rise_at  = -1;
    int fall_at  = -1;
    int stop_lat = 0;
    bit ack_mode = 1'b1;
    bit prev_busy = 1'b0;

    int fall_cyc        = -100;
    int last_start_cyc  = -100;
    int last_err_cyc    = -100;
    int last_start_id   = -1;
    int gap_since_fall  = 0;
    int start_after_err = 0;
    int ack_delay       = 0;
    int start_count     = 0;
    int stop_count      = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        ph       = PH_IDLE;
        m_pend   = '0;
        m_id     = 0;
        e_start  = 1'b0;
        e_stop   = 1'b0;
        e_err    = 1'b0;
        e_active = 1'b0;
    endtask

    task automatic modelEdge(input logic [N-1:0] req, input logic m, input logic b);
        logic [N-1:0] cand;
        logic [N-1:0] kbit;
        int k;
        int j;
        bit try_start;
        bit issued;
        cand      = m_pend | req;
        k         = lowest(cand);
        j         = lowest(cand & PMASK);
        try_start = 1'b0;
        issued    = 1'b0;
        e_start   = 1'b0;
        e_stop    = 1'b0;
        e_err     = 1'b0;
        case (ph)
            PH_IDLE: try_start = 1'b1;
            PH_WAIT: begin
                if (m) begin
                    e_stop = 1'b1;
                    ph     = PH_STOPW;
                end else if (b) begin
                    ph = PH_PLAY;
                end else if (cyc + 1 == start_at + A) begin
                    e_err    = 1'b1;
                    ph       = PH_GAP;
                    gap_last = cyc + G;
                end
            end
            PH_PLAY: begin
                if (m) begin
                    e_stop = 1'b1;
                    ph     = PH_STOPW;
                end else if (!b) begin
                    ph       = PH_GAP;
                    gap_last = cyc + G;
                end else if (j >= 0 && j < m_id) begin
                    e_stop = 1'b1;
                    ph     = PH_STOPW;
                end
            end
            PH_STOPW: if (!b) try_start = 1'b1;
            PH_GAP:   if (cyc == gap_last) try_start = 1'b1;
            default: ;
        endcase
        if (try_start) begin
            if (!m && k >= 0) begin
                e_start  = 1'b1;
                m_id     = k;
                issued   = 1'b1;
                ph       = PH_WAIT;
                start_at = cyc + 1;
            end else begin
                ph = PH_IDLE;
            end
        end
        kbit = issued ? (N'(1) << k) : '0;
        if (m)
            m_pend = '0;
        else if ((m_pend & kbit) != '0)
            m_pend = (m_pend & ~kbit) | req;
        else
            m_pend = cand & ~kbit;
        e_active = (ph == PH_WAIT) || (ph == PH_PLAY) || (ph == PH_STOPW);
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic m);
        logic b;
        b = (rise_at >= 0) && (cyc >= rise_at) && (cyc < fall_at);
        if (prev_busy && !b) fall_cyc = cyc;
        prev_busy   = b;
        sfx_req     = req;
        mute        = m;
        player_busy = b;
        modelEdge(req, m, b);
        if (player_start) begin
            if (ack_mode) begin
                rise_at = cyc + 2;
                fall_at = cyc + 12;
            end else begin
                rise_at = -1;
            end
        end
        if (player_stop) begin
            if (rise_at < 0 || cyc + 1 < rise_at)
                rise_at = -1;
            else if (fall_at > cyc + 1 + stop_lat)
                fall_at = cyc + 1 + stop_lat;
        end
    endtask

    task automatic compareAll();
        checkOutput("start",   player_start, e_start);
        checkOutput("stop",    player_stop,  e_stop);
        checkOutput("id",      player_id,    m_id);
        checkOutput("pending", pending,      m_pend);
        checkOutput("active",  active,       e_active);
        checkOutput("ack_err", ack_err,      e_err);
        if (player_start) begin
            last_start_cyc  = cyc;
            last_start_id   = player_id;
            gap_since_fall  = cyc - fall_cyc;
            start_after_err = cyc - last_err_cyc;
            start_count++;
        end
        if (ack_err) begin
            last_err_cyc = cyc;
            ack_delay    = cyc - last_start_cyc;
        end
        if (player_stop) stop_count++;
    endtask

    task automatic stepCycle(input logic [N-1:0] req, input logic m);
        applyStimulus(req, m);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compareAll();
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_start"},   player_start, 1'b0);
        checkOutput({pfx, "_stop"},    player_stop,  1'b0);
        checkOutput({pfx, "_id"},      player_id,    2'd0);
        checkOutput({pfx, "_pending"}, pending,      4'b0000);
        checkOutput({pfx, "_active"},  active,       1'b0);
        checkOutput({pfx, "_ack_err"}, ack_err,      1'b0);
    endtask

    initial begin
        int snap_start;
        int snap_stop;
        logic [N-1:0] rreq;
        bit rmute;

        reset_n     = 1'b0;
        sfx_req     = '0;
        mute        = 1'b0;
        player_busy = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        cyc     = 0;

        // single request: start one cycle later with the requested id
        while (cyc < 5) stepCycle('0, 1'b0);
        stepCycle(4'b0010, 1'b0);
        checkOutput("tp1_start", player_start, 1'b1);
        checkOutput("tp1_id",    player_id,    2'd1);
        repeat (20) stepCycle('0, 1'b0);

        // two simultaneous requests: id 2 first, id 3 after the gap
        stepCycle(4'b1100, 1'b0);
        checkOutput("tp2_id",      player_id, 2'd2);
        checkOutput("tp2_pending", pending,   4'b1000);
        repeat (40) stepCycle('0, 1'b0);
        checkOutput("tp2_last_id", last_start_id,  3);
        checkOutput("tp2_gap",     gap_since_fall, G + 1);

        // preemption of id 2 by id 0, restart without a gap
        stop_lat = 0;
        stepCycle(4'b0100, 1'b0);
        repeat (4) stepCycle('0, 1'b0);
        stepCycle(4'b0001, 1'b0);
        checkOutput("tp3_stop",   player_stop, 1'b1);
        checkOutput("tp3_active", active,      1'b1);
        repeat (30) stepCycle('0, 1'b0);
        checkOutput("tp3_last_id", last_start_id,  0);
        checkOutput("tp3_nogap",   gap_since_fall, 1);

        // player never acknowledges
        ack_mode = 1'b0;
        stepCycle(4'b0010, 1'b0);
        stepCycle(4'b0100, 1'b0);
        repeat (30) stepCycle('0, 1'b0);
        checkOutput("tp4_ack_delay", ack_delay,       A);
        checkOutput("tp4_last_id",   last_start_id,   2);
        checkOutput("tp4_err_gap",   start_after_err, G);
        ack_mode = 1'b1;

        // mute during play with a pending effect
        stepCycle(4'b0010, 1'b0);
        repeat (4) stepCycle('0, 1'b0);
        stepCycle(4'b0100, 1'b0);
        checkOutput("tp5_pend_before", pending, 4'b0100);
        snap_start = start_count;
        snap_stop  = stop_count;
        repeat (6) stepCycle('0, 1'b1);
        stepCycle(4'b1000, 1'b1);
        stepCycle('0, 1'b1);
        checkOutput("tp5_stops",      stop_count - snap_stop,   1);
        checkOutput("tp5_starts",     start_count - snap_start, 0);
        checkOutput("tp5_pend_after", pending, 4'b0000);
        repeat (15) stepCycle('0, 1'b0);
        checkOutput("tp5_no_replay", start_count - snap_start, 0);

        // asynchronous reset in the middle of an effect
        stepCycle(4'b0100, 1'b0);
        repeat (5) stepCycle('0, 1'b0);
        checkOutput("tp6_active_before", active, 1'b1);
        reset_n = 1'b0;
        #1;
        checkAllZero("tp6_rst");
        modelReset();
        rise_at   = -1;
        fall_at   = -1;
        prev_busy = 1'b0;
        player_busy = 1'b0;
        sfx_req   = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // randomised traffic
        rmute = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!rmute && $urandom_range(0, 149) == 0) rmute = 1'b1;
            else if (rmute && $urandom_range(0, 9) == 0) rmute = 1'b0;
            if ($urandom_range(0, 199) == 0) ack_mode = !ack_mode;
            stop_lat = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) rreq = N'($urandom_range(1, 15));
            else rreq = '0;
            stepCycle(rreq, rmute);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
